// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the pipelined fetch slice.
// No ports; imported by fetch_stage and sync_fifo.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int          INSTR_BYTES      = 4;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 deep FIFO, async reset, sync flush.
// Ports: clk, rst, flush, push/push_data, pop/pop_data, empty, count.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    import riscv_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == FULL_C);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A pop frees the slot, so push+pop on a full queue is legal.
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push)
                               - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: empty/count qualify every read.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(push && w_full && !pop && !flush)
    );

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: pipelined IF; sequential imem requests, in-order
// responses queued with their PC, redirect flush with stale-drop.
// Ports: clk, reset (async high); imem_req_{valid,ready,addr};
//        imem_rsp_{valid,data}; redirect_{valid,pc};
//        if_{valid,ready,instr,pc,pcplus4} toward decode.
module fetch_stage #(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   =
        XLEN'(riscv_pkg::RESET_PC_DEFAULT),
    parameter int              IBUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pcplus4
);
    import riscv_pkg::*;

    if (!is_pow2(IBUF_DEPTH)) begin : g_bad_depth
        $error("IBUF_DEPTH must be a power of 2, >= 2");
    end

    localparam int CW = $clog2(IBUF_DEPTH) + 1;
    localparam int EW = 32 + XLEN;
    localparam logic [CW-1:0]   OUT_MAX = '1;
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(IBUF_DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_live;
    logic [CW-1:0]   w_out_next;
    logic [CW:0]     w_inflight;
    logic [XLEN-1:0] w_target;
    logic            w_accept;
    logic            w_rsp;
    logic            w_rsp_stale;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [EW-1:0]   w_push_data;
    logic [EW-1:0]   w_head;
    logic            w_unused;

    assign w_target   = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused   = ^redirect_pc[1:0];
    assign w_live     = r_outstanding - r_drop;
    assign w_inflight = {1'b0, w_count} + {1'b0, w_live};

    // Queued plus live requests never exceed the queue depth,
    // so every live response has a slot. The OUT_MAX term only
    // keeps the counter from wrapping when stale requests pile up
    // behind a very slow imem.
    assign imem_req_valid = !reset
                         && !redirect_valid
                         && (w_inflight < DEPTH_C)
                         && (r_outstanding != OUT_MAX);
    assign imem_req_addr  = r_fetch_pc;

    assign w_accept    = imem_req_valid && imem_req_ready;
    assign w_rsp       = imem_rsp_valid
                      && (r_outstanding != '0);
    assign w_rsp_stale = w_rsp && (r_drop != '0);
    assign w_push      = w_rsp && !w_rsp_stale
                      && !redirect_valid;
    assign w_pop       = if_valid && if_ready
                      && !redirect_valid;
    assign w_out_next  = r_outstanding
                       + CW'(w_accept)
                       - CW'(w_rsp);
    assign w_push_data = {imem_rsp_data, r_rsp_pc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                // Everything still in flight, including a
                // response landing now, belongs to the old path.
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
                r_drop     <= w_out_next;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + STEP;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + STEP;
                end
                if (w_rsp_stale) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst       (reset),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign if_valid   = !w_empty;
    assign if_instr   = w_empty ? NOP_INSTR
                                : w_head[EW-1:XLEN];
    assign if_pc      = w_empty ? RESET_PC
                                : w_head[XLEN-1:0];
    assign if_pcplus4 = if_pc + STEP;

endmodule
